// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs IW-bit input beats into IW*RATIO-bit output words with lane keep and last
module beat_packer #(
  parameter int IW    = 8,
  parameter int RATIO = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IW-1:0]         i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IW*RATIO-1:0]   o_data,
  output logic [RATIO-1:0]      o_keep,
  output logic                  o_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  // Assembly state: lanes collected so far for the word in progress
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW*RATIO-1:0]   asm_data_q, asm_data_d;
  logic [RATIO-1:0]      asm_keep_q, asm_keep_d;

  // Output word register
  logic                  out_valid_q, out_valid_d;
  logic [IW*RATIO-1:0]   out_data_q, out_data_d;
  logic [RATIO-1:0]      out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;

  // Assembly state merged with the beat currently on the input
  logic [IW*RATIO-1:0]   merged_data;
  logic [RATIO-1:0]      merged_keep;

  logic in_xfer;
  logic out_xfer;
  logic completing;

  // The output register can take a new word whenever it is empty or being drained
  assign o_ready    = !out_valid_q || i_ready;
  assign in_xfer    = i_valid && o_ready;
  assign out_xfer   = out_valid_q && i_ready;
  assign completing = (cnt_q == CNT_MAX) || i_last;

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_keep  = out_keep_q;
  assign o_last  = out_last_q;

  // Place the incoming beat into lane cnt on top of the lanes already collected
  always_comb begin
    merged_data = asm_data_q;
    merged_keep = asm_keep_q;
    for (int l = 0; l < RATIO; l++) begin
      if (cnt_q == CW'(l)) begin
        merged_data[l*IW +: IW] = i_data;
        merged_keep[l]          = 1'b1;
      end
    end
  end

  // Next-state: accumulate non-completing beats, hand complete words to the output register
  always_comb begin
    cnt_d       = cnt_q;
    asm_data_d  = asm_data_q;
    asm_keep_d  = asm_keep_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (completing) begin
        // Clearing the assembly data keeps unfilled lanes of the next partial word at zero
        out_valid_d = 1'b1;
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = i_last;
        asm_data_d  = '0;
        asm_keep_d  = '0;
        cnt_d       = '0;
      end else begin
        asm_data_d  = merged_data;
        asm_keep_d  = merged_keep;
        cnt_d       = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset discards any partial word
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q       <= '0;
      asm_data_q  <= '0;
      asm_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_data_q  <= asm_data_d;
      asm_keep_q  <= asm_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - directed self-checking bench for beat_packer (IW=8, RATIO=4)
module tb_beat_packer;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;

  int vectors;
  int miscompares;

  beat_packer #(.IW(8), .RATIO(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_keep  (o_keep),
    .o_last  (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    #1;
    chk("o_ready_before_beat", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic v, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
    chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
    chk({tag, "_data"},  o_data, d);
    chk({tag, "_keep"},  {28'd0, o_keep}, {28'd0, k});
    chk({tag, "_last"},  {31'd0, o_last}, {31'd0, l});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
    i_ready = 1'b1;

    // Reset state
    #2;
    chk_word("reset", 1'b0, 32'h0, 4'h0, 1'b0);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, o_ready}, 32'd1);

    // Full word with last on lane 3
    send(8'h11, 1'b0);
    chk("full_partial_valid", {31'd0, o_valid}, 32'd0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("full_partial_valid2", {31'd0, o_valid}, 32'd0);
    send(8'h44, 1'b1);
    chk_word("full", 1'b1, 32'h44332211, 4'hF, 1'b1);
    tick();
    chk("full_drained", {31'd0, o_valid}, 32'd0);

    // Short packet, then single-beat packet completing while the first drains
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk_word("short", 1'b1, 32'h0000BBAA, 4'b0011, 1'b1);
    send(8'h5A, 1'b1);
    chk_word("single", 1'b1, 32'h0000005A, 4'b0001, 1'b1);
    tick();
    chk("single_drained", {31'd0, o_valid}, 32'd0);

    // Downstream stall with a beat offered that must be ignored
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    i_ready = 1'b0;
    send(8'h04, 1'b0);
    chk_word("stall_word", 1'b1, 32'h04030201, 4'hF, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'h99;
    i_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_ready", {31'd0, o_ready}, 32'd0);
      chk_word("stall_hold", 1'b1, 32'h04030201, 4'hF, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, o_ready}, 32'd1);
    tick();
    chk("stall_drained", {31'd0, o_valid}, 32'd0);

    // Back-to-back: eight beats on consecutive cycles
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk_word("b2b_w0", 1'b1, 32'h04030201, 4'hF, 1'b0);
    send(8'h05, 1'b0);
    chk("b2b_w0_drained", {31'd0, o_valid}, 32'd0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    chk_word("b2b_w1", 1'b1, 32'h08070605, 4'hF, 1'b0);
    tick();
    chk("b2b_drained", {31'd0, o_valid}, 32'd0);

    // Mid-packet reset discards the partial word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    i_reset = 1'b1;
    #1;
    chk_word("midrst_async", 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    i_reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b1);
    chk_word("midrst_word", 1'b1, 32'h08070605, 4'hF, 1'b1);
    tick();
    chk("midrst_drained", {31'd0, o_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beat_packer.md
BEAT_PACKER -- requirements
Module: beat_packer

Interface
REQ-001 SHALL have parameter IW, default 8: input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4: input beats per output word; legal range 2..16.
REQ-003 SHALL have i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have i_valid  input  1  upstream beat valid.
REQ-006 SHALL have o_ready  output  1  upstream may transfer this cycle.
REQ-007 SHALL have i_data  input  IW  upstream beat data.
REQ-008 SHALL have i_last  input  1  upstream beat ends the packet.
REQ-009 SHALL have o_valid  output  1  packed word valid to downstream.
REQ-010 SHALL have i_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have o_data  output  IW*RATIO  packed word, registered.
REQ-012 SHALL have o_keep  output  RATIO  one bit per lane; 1 = lane holds a real beat, registered.
REQ-013 SHALL have o_last  output  1  word ends a packet, registered.

Function
REQ-014 SHALL define input transfer as i_valid && o_ready, and output transfer as o_valid && i_ready.
REQ-015 SHALL drive o_ready = !o_valid || i_ready, combinationally, with no dependence on i_valid.
REQ-016 SHALL ignore i_data and i_last in any cycle without an input transfer.
REQ-017 SHALL keep a lane counter cnt (0..RATIO-1) and an assembly register; beat k of a word goes to lane cnt, bits [cnt*IW +: IW], so the first beat sits in the least-significant lane.
REQ-018 SHALL mark a beat as completing when cnt == RATIO-1 or i_last == 1.
REQ-019 SHALL, on a non-completing input transfer, write the lane, set its keep bit and increment cnt, leaving o_valid, o_data, o_keep and o_last unchanged.
REQ-020 SHALL, on a completing input transfer, load o_data, o_keep and o_last from the assembly state plus the current beat on the next edge, set o_valid = 1, clear the assembly keep bits and data, and set cnt = 0.
REQ-021 SHALL set o_last = i_last of the completing beat; a full word without i_last has o_last = 0.
REQ-022 SHALL drive unused lanes of a partial word (keep bit 0) to all zeros in o_data.
REQ-023 SHALL have a latency of exactly one cycle from the completing input transfer to o_valid = 1.
REQ-024 SHALL clear o_valid on an output transfer that has no simultaneous completing input transfer.
REQ-025 SHALL, on a cycle with both an output transfer and a completing input transfer, load the new word and keep o_valid = 1, with no bubble.
REQ-026 SHALL hold o_valid, o_data, o_keep and o_last stable while o_valid && !i_ready.
REQ-027 SHALL sustain one input beat per cycle while i_ready stays 1.
REQ-028 SHALL treat i_last on the first beat of a word as a one-lane word: o_keep = 1 in lane 0 only, for example 4'b0001.
REQ-029 SHALL treat i_last on lane RATIO-1 as a full word with o_last = 1 and all keep bits set.

Reset
REQ-030 SHALL, while i_reset = 1, asynchronously force o_valid = 0, o_last = 0, o_keep = 0, o_data = 0, cnt = 0, and clear the assembly register.
REQ-031 SHALL discard any partial word on a reset asserted mid-packet; the first beat accepted after reset lands in lane 0.
REQ-032 SHALL drive o_ready = 1 during reset and in the first cycle after release, because o_valid = 0.

Verification
REQ-033 SHALL cover a full word: IW=8, RATIO=4, i_ready=1, beats 11,22,33,44 with i_last on 44 -> one cycle later o_data=32'h44332211, o_keep=4'b1111, o_last=1.
REQ-034 SHALL cover a short packet: beats AA then BB with i_last -> o_data=32'h0000BBAA, o_keep=4'b0011, o_last=1; the next packet's first beat lands in lane 0.
REQ-035 SHALL cover a downstream stall: word pending, i_ready=0 for 5 cycles -> o_ready=0, output fields held constant; on i_ready=1, o_ready=1 in the same cycle.
REQ-036 SHALL cover back-to-back traffic: 8 beats on consecutive cycles (01..08, no i_last), i_ready=1 -> words 32'h04030201 then 32'h08070605, o_last=0, with no input stall.
REQ-037 SHALL cover a mid-packet reset: beats 01,02 accepted, pulse i_reset, then beats 05,06,07,08 with i_last -> o_data=32'h08070605, o_keep=4'b1111.
REQ-038 SHALL cover a single-beat packet: beat 5A with i_last, cnt=0 -> o_data=32'h0000005A, o_keep=4'b0001, o_last=1.
